// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer: drives the hopper one coin per req/ack, largest denomination first.
// First coinReq 2 cycles after start; coinReq held until coinAck or ACK_TIMEOUT cycles (then fault).
module change_dispenser #(
  parameter int INV_WIDTH   = 8,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8:0]           changeAmt,
  input  logic                 invLoad,
  input  logic [INV_WIDTH-1:0] invDollar,
  input  logic [INV_WIDTH-1:0] invQuarter,
  input  logic [INV_WIDTH-1:0] invDime,
  input  logic [INV_WIDTH-1:0] invNickel,
  output logic                 coinReq,
  output logic [1:0]           coinType,
  input  logic                 coinAck,
  output logic                 busy,
  output logic                 done,
  output logic [8:0]           shortfall,
  output logic [8:0]           dispensed,
  output logic                 fault,
  output logic [INV_WIDTH-1:0] cntDollar,
  output logic [INV_WIDTH-1:0] cntQuarter,
  output logic [INV_WIDTH-1:0] cntDime,
  output logic [INV_WIDTH-1:0] cntNickel
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, FINISH} state_t;

  state_t         state, stateNext;
  logic [8:0]     remaining;
  logic [TW-1:0]  ackTimer;
  logic           selFound;
  logic [1:0]     selType;
  logic           ackSeen;
  logic           timedOut;
  logic [8:0]     reqValue;

  function automatic logic [8:0] coinValue(input logic [1:0] t);
    case (t)
      2'd3:    coinValue = 9'd100;
      2'd2:    coinValue = 9'd25;
      2'd1:    coinValue = 9'd10;
      default: coinValue = 9'd5;
    endcase
  endfunction

  assign busy     = (state != IDLE);
  assign reqValue = coinValue(coinType);
  assign ackSeen  = (state == REQ) && coinAck;
  // ackTimer holds the number of REQ cycles already spent, so this fires on the ACK_TIMEOUT-th one.
  assign timedOut = (state == REQ) && !coinAck && (ackTimer == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    selFound = 1'b0;
    selType  = 2'd0;
    if (remaining >= 9'd100 && cntDollar != '0) begin
      selFound = 1'b1;
      selType  = 2'd3;
    end else if (remaining >= 9'd25 && cntQuarter != '0) begin
      selFound = 1'b1;
      selType  = 2'd2;
    end else if (remaining >= 9'd10 && cntDime != '0) begin
      selFound = 1'b1;
      selType  = 2'd1;
    end else if (remaining >= 9'd5 && cntNickel != '0) begin
      selFound = 1'b1;
      selType  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = SELECT;
      SELECT:  stateNext = selFound ? REQ : FINISH;
      REQ: begin
        if (ackSeen)       stateNext = SELECT;
        else if (timedOut) stateNext = FINISH;
      end
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining  <= '0;
      ackTimer   <= '0;
      coinReq    <= 1'b0;
      coinType   <= 2'd0;
      done       <= 1'b0;
      shortfall  <= '0;
      dispensed  <= '0;
      fault      <= 1'b0;
      cntDollar  <= '0;
      cntQuarter <= '0;
      cntDime    <= '0;
      cntNickel  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (invLoad) begin
            cntDollar  <= invDollar;
            cntQuarter <= invQuarter;
            cntDime    <= invDime;
            cntNickel  <= invNickel;
          end
          if (start) begin
            remaining <= changeAmt;
            dispensed <= '0;
            shortfall <= '0;
            fault     <= 1'b0;
          end
        end
        SELECT: begin
          if (selFound) begin
            coinReq  <= 1'b1;
            coinType <= selType;
            ackTimer <= '0;
          end else begin
            done      <= 1'b1;
            shortfall <= remaining;
          end
        end
        REQ: begin
          if (coinAck) begin
            coinReq   <= 1'b0;
            ackTimer  <= '0;
            remaining <= remaining - reqValue;
            dispensed <= dispensed + reqValue;
            case (coinType)
              2'd3:    cntDollar  <= cntDollar  - INV_WIDTH'(1);
              2'd2:    cntQuarter <= cntQuarter - INV_WIDTH'(1);
              2'd1:    cntDime    <= cntDime    - INV_WIDTH'(1);
              default: cntNickel  <= cntNickel  - INV_WIDTH'(1);
            endcase
          end else if (timedOut) begin
            coinReq   <= 1'b0;
            ackTimer  <= '0;
            fault     <= 1'b1;
            done      <= 1'b1;
            shortfall <= remaining;
          end else begin
            ackTimer <= ackTimer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] changeAmt;
  logic       invLoad;
  logic [7:0] invDollar, invQuarter, invDime, invNickel;
  logic       coinReq;
  logic [1:0] coinType;
  logic       coinAck;
  logic       busy, done, fault;
  logic [8:0] shortfall, dispensed;
  logic [7:0] cntDollar, cntQuarter, cntDime, cntNickel;

  int total = 0;
  int bad   = 0;

  int minv[4];     // model inventory, index = coin type
  int expQ[$];
  int obsQ[$];
  int msf, mdisp;
  int reqCycles, doneCyc;

  change_dispenser #(.INV_WIDTH(8), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .changeAmt(changeAmt), .invLoad(invLoad),
    .invDollar(invDollar), .invQuarter(invQuarter), .invDime(invDime), .invNickel(invNickel),
    .coinReq(coinReq), .coinType(coinType), .coinAck(coinAck), .busy(busy), .done(done),
    .shortfall(shortfall), .dispensed(dispensed), .fault(fault),
    .cntDollar(cntDollar), .cntQuarter(cntQuarter), .cntDime(cntDime), .cntNickel(cntNickel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_cents(input int t);
    case (t)
      3: return 100;
      2: return 25;
      1: return 10;
      default: return 5;
    endcase
  endfunction

  // Greedy: once a denomination is too large or exhausted it stays unusable, so one descending pass suffices.
  task automatic model_payout(input int amt);
    int rem;
    rem = amt;
    expQ.delete();
    for (int t = 3; t >= 0; t--) begin
      while (rem >= coin_cents(t) && minv[t] > 0) begin
        rem -= coin_cents(t);
        minv[t]--;
        expQ.push_back(t);
      end
    end
    msf   = rem;
    mdisp = amt - rem;
  endtask

  task automatic load_inv(input int d, input int q, input int di, input int n);
    invDollar = d[7:0]; invQuarter = q[7:0]; invDime = di[7:0]; invNickel = n[7:0];
    invLoad = 1'b1;
    step();
    invLoad = 1'b0;
    minv[3] = d; minv[2] = q; minv[1] = di; minv[0] = n;
  endtask

  task automatic run_payout(input int amt, input int ack_dly, input bit noise);
    int  cyc, waitc;
    bit  got_done;
    obsQ.delete();
    reqCycles = 0;
    changeAmt = amt[8:0];
    start     = 1'b1;
    got_done  = 1'b0;
    cyc = 0;
    waitc = 0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      step();
      cyc++;
      start = 1'b0; invLoad = 1'b0; coinAck = 1'b0;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (coinReq) begin
          reqCycles++;
          if (waitc >= ack_dly) begin
            coinAck = 1'b1;
            obsQ.push_back(int'(coinType));
            waitc = 0;
          end else begin
            waitc++;
          end
        end else if (noise && $urandom_range(0, 1) == 1) begin
          coinAck = 1'b1;
        end
        if (noise && busy) begin
          start      = 1'($urandom_range(0, 1));
          invLoad    = 1'($urandom_range(0, 1));
          changeAmt  = 9'($urandom);
          invDollar  = 8'($urandom);
          invQuarter = 8'($urandom);
          invDime    = 8'($urandom);
          invNickel  = 8'($urandom);
        end
      end
    end
    doneCyc = cyc;
    check_val("done_seen", got_done, 1);
  endtask

  task automatic check_result();
    check_val("coin_count", obsQ.size(), expQ.size());
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
      check_val("coin_type", obsQ[i], expQ[i]);
    check_val("shortfall", shortfall, msf);
    check_val("dispensed", dispensed, mdisp);
    check_val("fault_clear", fault, 0);
    check_val("cnt_dollar", cntDollar, minv[3]);
    check_val("cnt_quarter", cntQuarter, minv[2]);
    check_val("cnt_dime", cntDime, minv[1]);
    check_val("cnt_nickel", cntNickel, minv[0]);
    step();
    check_val("done_one_cycle", done, 0);
    check_val("busy_after", busy, 0);
  endtask

  initial begin
    int  amt;
    bit  saw_done;
    rst_n = 1'b0; start = 1'b0; changeAmt = '0; invLoad = 1'b0; coinAck = 1'b0;
    invDollar = '0; invQuarter = '0; invDime = '0; invNickel = '0;
    step();
    step();
    check_val("rst_coinReq", coinReq, 0);
    check_val("rst_coinType", coinType, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_shortfall", shortfall, 0);
    check_val("rst_dispensed", dispensed, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_counts", {cntDollar, cntQuarter, cntDime, cntNickel}, 0);
    rst_n = 1'b1;
    step();

    // Greedy payout of 190 from five of each coin.
    load_inv(5, 5, 5, 5);
    model_payout(190);
    run_payout(190, 1, 0);
    check_result();

    // Inventory limit: only two dimes for 35 cents.
    load_inv(0, 0, 2, 0);
    model_payout(35);
    run_payout(35, 0, 0);
    check_result();

    // Zero amount, then odd residue.
    model_payout(0);
    run_payout(0, 0, 0);
    check_val("zero_latency", doneCyc, 2);
    check_val("zero_no_req", reqCycles, 0);
    check_result();
    load_inv(0, 0, 0, 5);
    model_payout(7);
    run_payout(7, 0, 0);
    check_result();

    // Hopper never acks: timeout after 16 request cycles.
    load_inv(0, 1, 0, 0);
    run_payout(25, 1000000, 0);
    check_val("to_req_cycles", reqCycles, 16);
    check_val("to_coinReq_low", coinReq, 0);
    check_val("to_fault", fault, 1);
    check_val("to_shortfall", shortfall, 25);
    check_val("to_dispensed", dispensed, 0);
    check_val("to_quarter", cntQuarter, 1);
    step();
    step();
    check_val("to_fault_sticky", fault, 1);
    model_payout(0);
    run_payout(0, 0, 0);
    check_result();

    // Noise on start/invLoad/changeAmt while busy and acks while coinReq is low.
    load_inv(3, 3, 3, 3);
    model_payout(180);
    run_payout(180, 2, 1);
    check_result();

    // Reset while waiting on the hopper.
    load_inv(2, 2, 2, 2);
    changeAmt = 9'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !coinReq; i++) step();
    check_val("rst_mid_in_req", coinReq, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("rst_mid_coinReq", coinReq, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_counts", {cntDollar, cntQuarter, cntDime, cntNickel}, 0);
    check_val("rst_mid_dispensed", dispensed, 0);
    saw_done = done;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check_val("rst_mid_no_done", saw_done, 0);
    load_inv(1, 2, 2, 2);
    model_payout(160);
    run_payout(160, 1, 0);
    check_result();

    // Randomized payouts.
    for (int k = 0; k < 25; k++) begin
      load_inv($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      amt = $urandom_range(0, 511);
      model_payout(amt);
      run_payout(amt, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      check_result();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
